// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, activation mode encodings and the rounding-constant helper
// for the conv requantise/activate datapath.
package conv_pkg;
    localparam int ACC_W = 20;
    localparam int ACT_W = 8;
    localparam logic MODE_RELU = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Half of one output LSB for round-half-up; callers cap sh so the constant fits their width.
    function automatic logic [31:0] round_const(input logic rnd, input logic [4:0] sh);
        return (rnd && sh != 5'd0) ? 32'd1 << (sh - 5'd1) : 32'd0;
    endfunction
endpackage

// File: rtl/conv_act_lane.sv
// conv_act_lane: combinational per-lane requantise datapath feeding the top's pipeline registers.
// Ports: din/offset/shifts/rnd/mode -> t1 (S1 input); t1_q (S1 reg) -> t2 (S2 input);
//        t2_q (S2 reg) -> y clamped to OUT_W bits and sat flag (S3 inputs).
module conv_act_lane import conv_pkg::*; #(
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = ACT_W
) (
    input  logic signed [IN_W-1:0] din,
    input  logic signed [IN_W-1:0] offset,
    input  logic [4:0]             pre_shift,
    input  logic [4:0]             post_shift,
    input  logic                   rnd,
    input  logic                   mode,
    input  logic signed [IN_W:0]   t1_q,
    input  logic signed [IN_W+1:0] t2_q,
    output logic signed [IN_W:0]   t1,
    output logic signed [IN_W+1:0] t2,
    output logic [OUT_W-1:0]       y,
    output logic                   sat
);
    localparam logic [4:0] SH_MAX = 5'(IN_W + 1);
    localparam logic signed [IN_W+1:0] HI = {{(IN_W+3-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W+1:0] LO_SAT = ~HI;

    logic signed [IN_W-1:0] pre;
    logic signed [IN_W+1:0] sum, lo, c;

    always_comb begin
        // Shifts past the width naturally collapse to all sign bits.
        pre = din >>> pre_shift;
        t1 = {pre[IN_W-1], pre} - {offset[IN_W-1], offset};
        // Rounding constant capped so it always fits the IN_W+2 sum without overflow.
        sum = {t1_q[IN_W], t1_q} + (IN_W+2)'(round_const(rnd, post_shift > SH_MAX ? SH_MAX : post_shift));
        t2 = sum >>> post_shift;
        lo = mode == MODE_SAT ? LO_SAT : '0;
        c = t2_q > HI ? HI : t2_q < lo ? lo : t2_q;
        y = c[OUT_W-1:0];
        sat = c != t2_q;
    end
endmodule

// File: rtl/conv_act_requant.sv
// conv_act_requant: 3-stage streaming requantise + ReLU/saturate stage with frame-end tagging.
// Ports: cfg_* latched on cfg_we while idle; in_valid/in_ready/in_data (LANES x IN_W signed);
//        out_valid/out_ready/out_data (LANES x OUT_W), out_last, out_sat per lane;
//        busy = any stage valid; sat_sticky = saturation seen since last config write.
module conv_act_requant import conv_pkg::*; #(
    parameter int LANES = 4,
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = ACT_W,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [4:0]             cfg_pre_shift,
    input  logic [IN_W-1:0]        cfg_offset,
    input  logic [4:0]             cfg_post_shift,
    input  logic                   cfg_round,
    input  logic                   cfg_mode,
    input  logic [CNT_W-1:0]       cfg_frame_beats,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_last,
    output logic [LANES-1:0]       out_sat,
    output logic                   busy,
    output logic                   sat_sticky
);
    logic [4:0] pre_q, post_q;
    logic signed [IN_W-1:0] off_q;
    logic rnd_q, mode_q;
    logic [CNT_W-1:0] fb_q, ic, fb_m1;
    logic s1_v, s2_v, s1_l, s2_l;
    logic [LANES*(IN_W+1)-1:0] s1_t, t1_d;
    logic [LANES*(IN_W+2)-1:0] s2_t, t2_d;
    logic [LANES*OUT_W-1:0] y_d;
    logic [LANES-1:0] sat_d;
    logic adv, acc, last_d;

    // Whole pipe moves together; bubbles are kept, never squeezed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign acc      = in_valid && adv;
    assign busy     = s1_v || s2_v || out_valid;
    assign fb_m1    = fb_q == '0 ? '0 : fb_q - 1'b1;
    assign last_d   = ic == fb_m1;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        conv_act_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
            .din        (in_data[i*IN_W +: IN_W]),
            .offset     (off_q),
            .pre_shift  (pre_q),
            .post_shift (post_q),
            .rnd        (rnd_q),
            .mode       (mode_q),
            .t1_q       (s1_t[i*(IN_W+1) +: IN_W+1]),
            .t2_q       (s2_t[i*(IN_W+2) +: IN_W+2]),
            .t1         (t1_d[i*(IN_W+1) +: IN_W+1]),
            .t2         (t2_d[i*(IN_W+2) +: IN_W+2]),
            .y          (y_d[i*OUT_W +: OUT_W]),
            .sat        (sat_d[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            post_q     <= '0;
            off_q      <= '0;
            rnd_q      <= 1'b0;
            mode_q     <= MODE_RELU;
            fb_q       <= CNT_W'(1);
            ic         <= '0;
            s1_v       <= 1'b0;
            s1_l       <= 1'b0;
            s1_t       <= '0;
            s2_v       <= 1'b0;
            s2_l       <= 1'b0;
            s2_t       <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_sat    <= '0;
            sat_sticky <= 1'b0;
        end else begin
            // Config only changes with the pipe empty, so every stage sees one consistent set.
            if (cfg_we && !busy && !acc) begin
                pre_q      <= cfg_pre_shift;
                post_q     <= cfg_post_shift;
                off_q      <= cfg_offset;
                rnd_q      <= cfg_round;
                mode_q     <= cfg_mode;
                fb_q       <= cfg_frame_beats;
                sat_sticky <= 1'b0;
            end else if (out_valid && out_ready && |out_sat) begin
                sat_sticky <= 1'b1;
            end
            if (acc) ic <= last_d ? '0 : ic + 1'b1;
            if (adv) begin
                s1_v      <= acc;
                s1_l      <= acc && last_d;
                s1_t      <= t1_d;
                s2_v      <= s1_v;
                s2_l      <= s1_l;
                s2_t      <= t2_d;
                out_valid <= s2_v;
                out_last  <= s2_l;
                out_data  <= y_d;
                out_sat   <= sat_d;
            end
        end
    end
endmodule
